// File: rtl/key_schedule_ctrl_pkg.sv
// Shared definitions for the RC5-style key schedule controller:
// FSM state encoding, the RC5-32 magic constants and a small helper.
package key_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_MIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_rotl_var.sv
// Variable left rotate of a W-bit word by a log2(W)-bit amount.
module rotl_var #(
  parameter int W = 32
) (
  input  logic [W-1:0]         data_i,
  input  logic [$clog2(W)-1:0] amt_i,
  output logic [W-1:0]         rot_o
);

  logic [2*W-1:0] dbl;

  // Shift a doubled copy; the upper half is the rotated word.
  always_comb begin
    dbl   = {data_i, data_i} << amt_i;
    rot_o = dbl[2*W-1:W];
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// RC5-style key expansion controller: loads the key into L, fills S with
// the P/Q progression, then runs 3*max(t,c) mixing rounds over S and L.
// Optional build macro KEY_SCHED_ZEROIZE_EN clears L, A, B and the captured
// key in the DONE cycle; S and all timing are unaffected by it.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; S table held and readable
// LOAD    | b cycles, key bytes b-1..0 shifted into L
// INIT    | t cycles, S[k] = P + k*Q
// MIX     | 3*max(t,c) cycles of A/B mixing into S and L
// DONE    | one cycle, done pulse, then back to IDLE
module key_schedule_ctrl
  import key_sched_pkg::*;
#(
  parameter int w = 32,
  parameter int b = 16,
  parameter int t = 26,
  parameter int u = 4,
  parameter int c = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*b-1:0]       key,
  input  logic [w-1:0]         pW,
  input  logic [w-1:0]         qW,
  input  logic [$clog2(t)-1:0] s_rd_addr,
  output logic [w-1:0]         s_rd_data,
  output logic                 busy,
  output logic                 done
);

  localparam int AW      = $clog2(t);
  localparam int CW      = (c > 1) ? $clog2(c) : 1;
  localparam int RW      = $clog2(w);
  localparam int MIX_LEN = 3 * max_int(t, c);
  localparam int CNTW    = $clog2(max_int(max_int(b, t), MIX_LEN) + 1);

  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(b - 1);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(t - 1);
  localparam logic [CNTW-1:0] CNT_MIX  = CNTW'(MIX_LEN - 1);
  localparam logic [AW-1:0]   I_LAST   = AW'(t - 1);
  localparam logic [CW-1:0]   J_LAST   = CW'(c - 1);

  state_e state_q, state_d;

  logic [8*b-1:0] key_q;
  logic [w-1:0]   p_q, q_q;
  logic [w-1:0]   a_q, b_q;
  logic [w-1:0]   l_q [c];
  logic [w-1:0]   s_q [t];
  logic [CNTW-1:0] cnt_q;
  logic [AW-1:0]  i_q;
  logic [CW-1:0]  j_q;

  logic           tc;
  logic [7:0]     key_byte;
  logic [CW-1:0]  load_l_idx;
  logic [w-1:0]   load_l_next;
  logic [w-1:0]   mix_sum_a, mix_sum_b, ab_sum;
  logic [w-1:0]   a_new, b_new;

  // Phase counter counts down; zero marks the last cycle of the phase.
  assign tc = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (tc)    state_d = ST_INIT;
      ST_INIT: if (tc)    state_d = ST_MIX;
      ST_MIX:  if (tc)    state_d = ST_DONE;
      ST_DONE:            state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == ST_LOAD) || (state_q == ST_INIT) || (state_q == ST_MIX);
    done = (state_q == ST_DONE);
  end

  // In LOAD the phase counter doubles as the byte index (b-1 down to 0).
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < b; k++)
      if (cnt_q == CNTW'(k)) key_byte = key_q[8*k +: 8];
  end

  // L word targeted by the current key byte and its shifted-in value.
  always_comb begin
    load_l_idx  = CW'(cnt_q / CNTW'(u));
    load_l_next = (l_q[load_l_idx] << 8) + {{(w-8){1'b0}}, key_byte};
  end

  // Mixing round arithmetic; A' feeds both the S write and the B path.
  always_comb begin
    mix_sum_a = s_q[i_q] + a_q + b_q;
    ab_sum    = a_new + b_q;
    mix_sum_b = l_q[j_q] + ab_sum;
  end

  rotl_var #(.W(w)) u_rotl_a (
    .data_i (mix_sum_a),
    .amt_i  (RW'(3)),
    .rot_o  (a_new)
  );

  rotl_var #(.W(w)) u_rotl_b (
    .data_i (mix_sum_b),
    .amt_i  (ab_sum[RW-1:0]),
    .rot_o  (b_new)
  );

  // Datapath: key capture, L load, S init and the mixing rounds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q <= '0;
      p_q   <= '0;
      q_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      for (int k = 0; k < c; k++) l_q[k] <= '0;
      for (int k = 0; k < t; k++) s_q[k] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q <= key;
            p_q   <= pW;
            q_q   <= qW;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= CNT_LOAD;
            i_q   <= '0;
            j_q   <= '0;
            for (int k = 0; k < c; k++) l_q[k] <= '0;
          end
        end
        ST_LOAD: begin
          l_q[load_l_idx] <= load_l_next;
          if (tc) cnt_q <= CNT_INIT;
          else    cnt_q <= cnt_q - CNTW'(1);
        end
        ST_INIT: begin
          s_q[i_q] <= (i_q == '0) ? p_q : s_q[i_q - AW'(1)] + q_q;
          if (tc) begin
            cnt_q <= CNT_MIX;
            i_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
            i_q   <= i_q + AW'(1);
          end
        end
        ST_MIX: begin
          s_q[i_q] <= a_new;
          l_q[j_q] <= b_new;
          a_q      <= a_new;
          b_q      <= b_new;
          i_q      <= (i_q == I_LAST) ? '0 : i_q + AW'(1);
          j_q      <= (j_q == J_LAST) ? '0 : j_q + CW'(1);
          if (!tc) cnt_q <= cnt_q - CNTW'(1);
        end
        ST_DONE: begin
`ifdef KEY_SCHED_ZEROIZE_EN
          key_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
          for (int k = 0; k < c; k++) l_q[k] <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Combinational S read port; out-of-range addresses return zero.
  always_comb begin
    s_rd_data = '0;
    for (int k = 0; k < t; k++)
      if (s_rd_addr == AW'(k)) s_rd_data = s_q[k];
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter w, default 32: word width in bits; power of two.
REQ-002 Parameter b, default 16: key length in bytes.
REQ-003 Parameter t, default 26: S-table size in words.
REQ-004 Parameter u, default 4: bytes per word, equal to w/8.
REQ-005 Parameter c, default 4: L-array size in words, equal to max(1, ceil(b/u)).
REQ-006 clk  input  1: single clock; all state changes on its rising edge.
REQ-007 rst  input  1: asynchronous, active-low reset.
REQ-008 start  input  1: one-cycle request to expand the current key.
REQ-009 key  input  8*b: secret key; byte i = key[8i+7:8i].
REQ-010 pW  input  w: magic constant P.
REQ-011 qW  input  w: magic constant Q.
REQ-012 s_rd_addr  input  ceil(log2 t): S-table read index.
REQ-013 s_rd_data  output  w: S[s_rd_addr], combinational.
REQ-014 busy  output  1: high from the cycle after start is accepted through the last MIX cycle.
REQ-015 done  output  1: one-cycle pulse when the expansion completes.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, INIT, MIX and DONE.
REQ-017 IDLE->LOAD on start=1; start in any other state SHALL be ignored.
REQ-018 On acceptance, the block SHALL capture key, pW and qW, clear L[0..c-1], A and B, and set the byte index to b-1.
REQ-019 LOAD SHALL last b cycles; each cycle processes byte i from b-1 down to 0: L[i/u] <= (L[i/u] << 8) + byte i, truncated to w bits.
REQ-020 INIT SHALL last t cycles: S[0] <= P, then S[k] <= S[k-1] + Q mod 2^w for k = 1..t-1.
REQ-021 MIX SHALL last exactly 3*max(t,c) cycles, with i and j starting at 0.
REQ-022 Each MIX cycle SHALL compute A' = rotl(S[i]+A+B, 3) and B' = rotl(L[j]+A'+B, (A'+B) mod w), then write S[i] <= A', L[j] <= B', A <= A', B <= B'.
REQ-023 In MIX, i SHALL wrap from t-1 to 0 and j SHALL wrap from c-1 to 0, each independently.
REQ-024 After the last MIX cycle the block SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-025 done SHALL be asserted exactly 1+b+t+3*max(t,c) cycles after the start sample; this is 121 at the default parameters.
REQ-026 The S table SHALL hold its contents in IDLE and be readable at any time; reads during busy return in-progress values.
REQ-027 A start arriving in the same cycle that DONE is active SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately force IDLE and set busy=0, done=0, A=0, B=0, all L to 0, all S to 0 and all indices to 0, including mid-operation.
REQ-029 After rst rises, the block SHALL accept start in the first clock edge.

Configuration
REQ-030 With KEY_SCHED_ZEROIZE_EN defined, the DONE cycle SHALL clear L[0..c-1], A, B and the captured key register to 0.
REQ-031 Without KEY_SCHED_ZEROIZE_EN, L, A, B and the captured key SHALL retain their final values until the next start or reset.
REQ-032 S contents and timing SHALL be identical with and without KEY_SCHED_ZEROIZE_EN.

Structure
REQ-033 Shared package key_sched_pkg SHALL hold the state encoding and the RC5 constants P32 = 0xB7E15163 and Q32 = 0x9E3779B9.
REQ-034 Variable left rotate SHALL be a separate sub-module rotl_var (w-bit data, log2(w)-bit amount), instantiated twice.

Verification
REQ-035 key=0, pW=0, qW=0, start -> done at cycle 121 and every S[k] reads 0x00000000.
REQ-036 key=0, pW=P32, qW=Q32 -> all 26 S words match the RC5-32/12/16 golden model for the zero key.
REQ-037 Random 16-byte key with P32/Q32 -> all S words match the golden model; busy stays high for exactly 120 cycles.
REQ-038 start pulsed during MIX and during DONE -> ignored; a single done pulse occurs and S is unchanged from the single-run result.
REQ-039 rst=0 asserted in the middle of MIX -> busy=0 and S[5]=0 immediately; a new start then yields the correct table.
REQ-040 With KEY_SCHED_ZEROIZE_EN defined, after done the internal L and A/B registers read 0; without it, they hold their final values.
